// File: rtl/sched_dispatch_ctrl.sv
// Scheduler front end: ingress queue, tick/repair controller and
// one-task-per-cycle core dispatch with optional randomised scan start.
module sched_dispatch_ctrl #(
  parameter int W        = 42,
  parameter int Q_DEPTH  = 16,
  parameter int CORE     = 16,
  parameter int TICK     = 8,
  parameter int RP_TICKS = 64,
  parameter int RP_LEN   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [W-2:0]               task_in,
  input  logic [CORE-1:0]            core_free,
  input  logic                       secure_mode,
  input  logic                       seed_ld,
  input  logic [15:0]                seed,
  output logic                       disp_valid,
  output logic [$clog2(CORE)-1:0]    disp_core,
  output logic [W-2:0]               disp_task,
  output logic                       subtract,
  output logic                       repair_period,
  output logic                       action,
  output logic                       MQ_active,
  output logic [$clog2(Q_DEPTH):0]   q_count,
  output logic                       full,
  output logic                       ovf
);

  localparam int CW = $clog2(CORE);
  localparam int QW = $clog2(Q_DEPTH);
  localparam int TW = $clog2(TICK);
  localparam int RW = $clog2(RP_TICKS + 1);
  localparam int LW = $clog2(RP_LEN + 1);

  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DISP = 2'd1;
  localparam logic [1:0] S_REP  = 2'd2;

  logic [W-2:0]    mem [Q_DEPTH];
  logic [QW-1:0]   wr_ptr;
  logic [QW-1:0]   rd_ptr;
  logic [QW:0]     cnt;
  logic [1:0]      state;
  logic [TW-1:0]   tick_cnt;
  logic [RW-1:0]   rp_cnt;
  logic [LW-1:0]   rep_cnt;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_nxt;
  logic [CORE-1:0] mask;
  logic [CORE-1:0] avail;

  logic          q_empty;
  logic          push;
  logic          fire;
  logic          in_rep;
  logic          sub_w;
  logic          rp_hit;
  logic          rep_done;
  logic          found;
  logic [CW-1:0] start;
  logic [CW-1:0] sel;
  logic [CW-1:0] idx;

  assign q_empty  = (cnt == '0);
  assign full     = (cnt == (QW+1)'(Q_DEPTH));
  assign push     = wr && !full;
  assign in_rep   = (state == S_REP);
  assign avail    = core_free & ~mask;
  assign fire     = (state == S_DISP) && !q_empty && (|avail);
  assign sub_w    = !in_rep && (tick_cnt == TW'(TICK - 1));
  assign rp_hit   = sub_w && (rp_cnt == RW'(RP_TICKS - 1));
  assign rep_done = in_rep && (rep_cnt == LW'(RP_LEN - 1));
  assign start    = secure_mode ? lfsr[CW-1:0] : '0;
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign subtract      = sub_w;
  assign repair_period = in_rep;
  assign MQ_active     = !q_empty && !in_rep;
  assign q_count       = cnt;

  // Circular scan upward from start; index wraps since CORE is a power of 2
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < CORE; i++) begin
      idx = start + CW'(i);
      if (!found && avail[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= task_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + QW'(1);
      end
      if (fire) begin
        rd_ptr <= rd_ptr + QW'(1);
      end
      if (push && !fire) begin
        cnt <= cnt + (QW+1)'(1);
      end else if (!push && fire) begin
        cnt <= cnt - (QW+1)'(1);
      end
      if (wr && full) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      rp_cnt   <= '0;
      rep_cnt  <= '0;
    end else begin
      if (!in_rep) begin
        tick_cnt <= sub_w ? '0 : tick_cnt + TW'(1);
      end
      if (sub_w) begin
        rp_cnt <= rp_hit ? '0 : rp_cnt + RW'(1);
      end
      if (in_rep) begin
        rep_cnt <= rep_done ? '0 : rep_cnt + LW'(1);
      end
    end
  end

  // Repair entry overrides every other transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      action <= 1'b0;
    end else begin
      action <= rep_done;
      if (rp_hit) begin
        state <= S_REP;
      end else begin
        unique case (1'b1)
          (state == S_IDLE): begin
            if (!q_empty) state <= S_DISP;
          end
          (state == S_DISP): begin
            if (q_empty) state <= S_IDLE;
          end
          (state == S_REP): begin
            if (rep_done) state <= q_empty ? S_IDLE : S_DISP;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_valid <= 1'b0;
      disp_core  <= '0;
      disp_task  <= '0;
      mask       <= '0;
    end else begin
      disp_valid <= fire;
      mask       <= fire ? (CORE'(1) << sel) : '0;
      if (fire) begin
        disp_core <= sel;
        disp_task <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_INIT;
    end else if (seed_ld) begin
      lfsr <= (seed == 16'h0) ? LFSR_INIT : seed;
    end else if (fire) begin
      lfsr <= lfsr_nxt;
    end
  end

endmodule
